// File: rtl/serial_sum_collector.sv
// ---------------------------------------------------------------------------
// serial_sum_collector
//
// Collects the LSB-first sum bit stream of a bit-serial adder into parallel
// words, appends the adder's final carry, and queues the completed results in
// a small FIFO that is drained through a valid/ready handshake. The serial
// side never stalls: if the FIFO is full (and not being popped) the completed
// word is dropped and a sticky overrun flag is raised.
//
// Optional feature macro: SERIAL_SUM_PARITY_EN
//    When defined, each FIFO entry also stores even parity over
//    {cout, sum}, presented on out_parity for the head entry.
//
// Parameters:
//    WIDTH - sum word width; number of serial bits per frame (>= 2)
//    DEPTH - number of buffered results; power of two, >= 2
//
// Ports:
//    clk          rising-edge clock
//    reset        asynchronous, active-high reset
//    frame_start  abandon any partial word; restart at bit 0
//    bit_valid    sum_bit/carry_bit valid this cycle
//    sum_bit      serial sum bit, LSB first
//    carry_bit    adder carry-out, used on the last bit of a frame
//    out_valid    FIFO head holds a completed result
//    out_ready    consumer accepts the head this cycle
//    out_sum      sum word at the FIFO head
//    out_cout     carry-out at the FIFO head
//    out_parity   (SERIAL_SUM_PARITY_EN only) parity of the head entry
//    busy         a partial word is in progress
//    overrun      sticky: a completed word was dropped (FIFO full)
// ---------------------------------------------------------------------------
module serial_sum_collector #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             bit_valid,
   input  logic             sum_bit,
   input  logic             carry_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy,
`ifdef SERIAL_SUM_PARITY_EN
   output logic             out_parity,
`endif
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int AW = $clog2(DEPTH);
`ifdef SERIAL_SUM_PARITY_EN
   localparam int EW = WIDTH + 2;
`else
   localparam int EW = WIDTH + 1;
`endif
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // The frame state is carried entirely by the bit count; the enum is a
   // decoded view of it.
   typedef enum logic {
      ST_IDLE,
      ST_COLLECT
   } frame_state_e;

   frame_state_e      frame_state;
   logic [CW-1:0]     count_q, count_d, count_base;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic              word_done;
   logic [EW-1:0]     push_entry;

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     head;
   logic              fifo_empty, fifo_full;
   logic              pop, push_ok, drop;
   logic              overrun_q, overrun_d;

   // ---------------- frame collection ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         shift_q <= '0;
      end else begin
         count_q <= count_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      frame_state = (count_q == '0) ? ST_IDLE : ST_COLLECT;
      // frame_start restarts the count before any accompanying bit is
      // counted, so that bit becomes bit 0 of the new frame.
      count_base  = frame_start ? '0 : count_q;
      count_d     = count_base;
      shift_d     = shift_q;
      word_done   = 1'b0;
      if (bit_valid) begin
         shift_d = {sum_bit, shift_q[WIDTH-1:1]};
         if (count_base == LAST_BIT) begin
            count_d   = '0;
            word_done = 1'b1;
         end else begin
            count_d = count_base + CW'(1);
         end
      end
   end

   assign busy = (frame_state == ST_COLLECT);

`ifdef SERIAL_SUM_PARITY_EN
   assign push_entry = {^{carry_bit, shift_d}, carry_bit, shift_d};
`else
   assign push_entry = {carry_bit, shift_d};
`endif

   // ---------------- result FIFO ----------------
   // Pointers are one bit wider than the index: equal pointers mean empty,
   // equal index with differing wrap bit means full.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign pop     = !fifo_empty && out_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // still succeeds (it lands in the slot being vacated).
   assign push_ok = word_done && (!fifo_full || pop);
   assign drop    = word_done && fifo_full && !pop;

   always_comb begin
      wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overrun_d = overrun_q | drop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         overrun_q <= overrun_d;
      end
   end

   // Entries are cleared on reset so the head outputs read zero afterwards.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               mem_q[gi] <= '0;
            end else if (push_ok && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
               mem_q[gi] <= push_entry;
            end
         end
      end
   endgenerate

   assign head      = mem_q[rd_ptr_q[AW-1:0]];
   assign out_valid = !fifo_empty;
   assign out_sum   = head[WIDTH-1:0];
   assign out_cout  = head[WIDTH];
   assign overrun   = overrun_q;
`ifdef SERIAL_SUM_PARITY_EN
   assign out_parity = head[WIDTH+1];
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// ---------------------------------------------------------------------------
// tb_serial_sum_collector
//
// Directed bench for serial_sum_collector (WIDTH=4, DEPTH=2). Inputs change
// on the falling edge; outputs are examined on the falling edge, half a
// cycle after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_serial_sum_collector;

   logic       clk;
   logic       reset;
   logic       frame_start;
   logic       bit_valid;
   logic       sum_bit;
   logic       carry_bit;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_sum;
   logic       out_cout;
   logic       busy;
   logic       overrun;
`ifdef SERIAL_SUM_PARITY_EN
   logic       out_parity;
`endif

   int total_checks  = 0;
   int passed_checks = 0;

   serial_sum_collector #(.WIDTH(4), .DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .bit_valid   (bit_valid),
      .sum_bit     (sum_bit),
      .carry_bit   (carry_bit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_cout    (out_cout),
      .busy        (busy),
`ifdef SERIAL_SUM_PARITY_EN
      .out_parity  (out_parity),
`endif
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) begin
         passed_checks++;
         $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One serial cycle: wait for the falling edge, then drive the inputs.
   task automatic cyc(input logic bv, input logic sb, input logic cb, input logic fs);
      @(negedge clk);
      bit_valid   = bv;
      sum_bit     = sb;
      carry_bit   = cb;
      frame_start = fs;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Four consecutive bits, LSB first, carry on the last.
   task automatic send_frame(input logic [3:0] val, input logic c);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, val[i], (i == 3) ? c : 1'b0, 1'b0);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      reset       = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      bit_valid   = 1'b0;
      sum_bit     = 1'b0;
      carry_bit   = 1'b0;
      out_ready   = 1'b0;

      // ---- reset state ----
      #1;
      chk("rst_valid",   32'(out_valid), 32'd0);
      chk("rst_sum",     32'(out_sum),   32'd0);
      chk("rst_cout",    32'(out_cout),  32'd0);
      chk("rst_busy",    32'(busy),      32'd0);
      chk("rst_overrun", 32'(overrun),   32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // ---- basic word: 1,1,0,1 LSB first, carry 1 -> 0xB ----
      out_ready = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("basic_busy_mid", 32'(busy),      32'd1);
      chk("basic_no_early", 32'(out_valid), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_sum",   32'(out_sum),   32'hB);
      chk("basic_cout",  32'(out_cout),  32'd1);
      chk("basic_busy",  32'(busy),      32'd0);
      idle();
      chk("basic_popped", 32'(out_valid), 32'd0);

      // ---- backpressure and overrun ----
      out_ready = 1'b0;
      send_frame(4'h3, 1'b0);
      send_frame(4'h5, 1'b1);
      chk("bp_no_ovr_yet", 32'(overrun), 32'd0);
      send_frame(4'hA, 1'b0);
      idle();
      chk("bp_overrun", 32'(overrun),   32'd1);
      chk("bp_valid",   32'(out_valid), 32'd1);
      chk("bp_head0",   32'(out_sum),   32'h3);
      chk("bp_cout0",   32'(out_cout),  32'd0);
      idle();
      chk("bp_hold",    32'(out_sum),   32'h3);
      out_ready = 1'b1;
      idle();
      chk("bp_head1",   32'(out_sum),   32'h5);
      chk("bp_cout1",   32'(out_cout),  32'd1);
      idle();
      chk("bp_empty",   32'(out_valid), 32'd0);
      chk("bp_sticky",  32'(overrun),   32'd1);

      pulse_reset();
      chk("rst2_overrun", 32'(overrun), 32'd0);

      // ---- full FIFO with simultaneous pop ----
      out_ready = 1'b0;
      send_frame(4'h1, 1'b0);
      send_frame(4'h2, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
      chk("fp_overrun", 32'(overrun),   32'd0);
      chk("fp_valid",   32'(out_valid), 32'd1);
      chk("fp_head",    32'(out_sum),   32'h2);
      chk("fp_cout",    32'(out_cout),  32'd1);
      out_ready = 1'b1;
      idle();
      chk("fp_second",  32'(out_sum),   32'hC);
      chk("fp_cout2",   32'(out_cout),  32'd0);
      chk("fp_valid2",  32'(out_valid), 32'd1);
      idle();
      chk("fp_empty",   32'(out_valid), 32'd0);

      // ---- frame_start mid-word ----
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("fs_busy",    32'(busy),      32'd1);
      chk("fs_no_emit", 32'(out_valid), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("fs_no_emit2", 32'(out_valid), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      chk("fs_valid",   32'(out_valid), 32'd1);
      chk("fs_sum",     32'(out_sum),   32'h9);
      chk("fs_cout",    32'(out_cout),  32'd0);
      idle();
      chk("fs_once",    32'(out_valid), 32'd0);

      // ---- reset mid-operation ----
      out_ready = 1'b0;
      send_frame(4'h1, 1'b0);
      send_frame(4'h2, 1'b0);
      send_frame(4'h3, 1'b0);
      idle();
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
      chk("rm_one_left", 32'(out_sum), 32'h2);
      chk("rm_ovr_set",  32'(overrun), 32'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      bit_valid = 1'b0;
      chk("rm_busy_pre", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rm_valid",   32'(out_valid), 32'd0);
      chk("rm_busy",    32'(busy),      32'd0);
      chk("rm_overrun", 32'(overrun),   32'd0);
      chk("rm_sum",     32'(out_sum),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      send_frame(4'h6, 1'b0);
      idle();
      chk("rm_new_valid", 32'(out_valid), 32'd1);
      chk("rm_new_sum",   32'(out_sum),   32'h6);
      out_ready = 1'b1;
      idle();
      chk("rm_only_one",  32'(out_valid), 32'd0);

      // ---- gapped input: 0x9, carry 1 ----
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      chk("gap_busy1", 32'(busy), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      chk("gap_busy2", 32'(busy), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      chk("gap_busy3",  32'(busy),      32'd1);
      chk("gap_novalid", 32'(out_valid), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      idle();
      chk("gap_valid", 32'(out_valid), 32'd1);
      chk("gap_sum",   32'(out_sum),   32'h9);
      chk("gap_cout",  32'(out_cout),  32'd1);
      chk("gap_idle",  32'(busy),      32'd0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
